dmem_responder: RTL

Data-memory responder serving load/store requests from the CPU MEM stage over a req/ack handshake with configurable access latency. It is the responder end of the CPU's data-memory interface and holds word-organised storage internally. It drives a busy flag the pipeline uses to stall IF/ID/EX/MEM while an access is outstanding.

---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/dmem_if.sv | 48 ++++
 rtl/dmem_array.sv | 53 +++++
 rtl/dmem_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional byte-strobe support is selected with the DMEM_BYTE_EN_EN macro.
package dmem_pkg;

    // Responder FSM: idle, counting down the access latency, presenting the ack
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int OFF_W      = 2;   // byte-offset bits inside a word

    // Number of index bits needed to address depth_words words
    function automatic int idx_width(input int depth_words);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth_words) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Byte lanes a strobe may touch for an access starting at byte offset off:
    // word-aligned may use any lane, halfword-aligned the upper half only,
    // odd offsets only their own byte.
    function automatic logic [WORD_BYTES-1:0] lane_mask(input logic [OFF_W-1:0] off);
        logic [WORD_BYTES-1:0] m;
        case (off)
            2'd0:    m = 4'b1111;
            2'd1:    m = 4'b0010;
            2'd2:    m = 4'b1100;
            default: m = 4'b1000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU data-memory bus between the MEM stage (master) and the responder (slave).
// Byte strobes be_i exist only when DMEM_BYTE_EN_EN is defined.
interface dmem_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic                  req_i;
    logic                  we_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [31:0]           wdata_i;
`ifdef DMEM_BYTE_EN_EN
    logic [WORD_BYTES-1:0] be_i;
`endif
    logic                  ack_o;
    logic [31:0]           rdata_o;
    logic                  err_o;
    logic                  busy_o;

    modport master (
`ifdef DMEM_BYTE_EN_EN
        output be_i,
`endif
        output req_i,
        output we_i,
        output addr_i,
        output wdata_i,
        input  ack_o,
        input  rdata_o,
        input  err_o,
        input  busy_o
    );

    modport slave (
`ifdef DMEM_BYTE_EN_EN
        input  be_i,
`endif
        input  req_i,
        input  we_i,
        input  addr_i,
        input  wdata_i,
        output ack_o,
        output rdata_o,
        output err_o,
        output busy_o
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with registered read and write enable.
// With DMEM_BYTE_EN_EN defined, writes honour per-byte strobes.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = idx_width(DEPTH_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      addr_i,
    input  logic [31:0]           wdata_i,
`ifdef DMEM_BYTE_EN_EN
    input  logic [WORD_BYTES-1:0] be_i,
`endif
    output logic [31:0]           rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

`ifdef DMEM_BYTE_EN_EN
    // Strobed write or registered read; read data holds while idle or writing
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < WORD_BYTES; b++) begin
                    if (be_i[b]) begin
                        mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end
`else
    // Full-word write or registered read; read data holds while idle or writing
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end
`endif

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time from the MEM stage,
// acks it a fixed LATENCY cycles later and raises busy_o while outstanding.
// Define DMEM_BYTE_EN_EN to add byte strobes (be_i) on the bus.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3,
    parameter int ADDR_W      = 32
) (
    input  logic   clk_i,
    input  logic   rst_i,
    dmem_if.slave  bus
);

    localparam int IDX_W = idx_width(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
`ifdef DMEM_BYTE_EN_EN
    logic [WORD_BYTES-1:0] be_q, be_d;
    logic [WORD_BYTES-1:0] acc_be;
`endif
    logic                  err_q, err_d;
    logic                  zero_q, zero_d;   // forces rdata_o to 0 (stores, errors, after reset)

    logic                  acc_we;
    logic [ADDR_W-1:0]     acc_addr;
    logic                  acc_err;
    logic                  out_of_range;
    logic                  misaligned;
    logic                  enter_resp;
    logic                  ram_en;
    logic                  ram_we;
    logic [IDX_W-1:0]      ram_addr;
    logic [31:0]           ram_rdata;

    // Access attributes: straight from the bus while idle (needed when
    // LATENCY=1 enters RESP on the accept edge), otherwise the captured copy
    always_comb begin
        acc_we   = we_q;
        acc_addr = addr_q;
`ifdef DMEM_BYTE_EN_EN
        acc_be   = be_q;
`endif
        if (state_q == IDLE) begin
            acc_we   = bus.we_i;
            acc_addr = bus.addr_i;
`ifdef DMEM_BYTE_EN_EN
            acc_be   = bus.be_i;
`endif
        end
        out_of_range = (acc_addr >> (IDX_W + OFF_W)) != '0;
`ifdef DMEM_BYTE_EN_EN
        misaligned   = |(acc_be & ~lane_mask(acc_addr[OFF_W-1:0]));
`else
        misaligned   = acc_addr[OFF_W-1:0] != '0;
`endif
        acc_err  = out_of_range | misaligned;
        ram_addr = acc_addr[IDX_W+OFF_W-1:OFF_W];
    end

    // Next-state, request capture and RAM control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef DMEM_BYTE_EN_EN
        be_d       = be_q;
`endif
        err_d      = err_q;
        zero_d     = zero_q;
        enter_resp = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    we_d    = bus.we_i;
                    addr_d  = bus.addr_i;
                    wdata_d = bus.wdata_i;
`ifdef DMEM_BYTE_EN_EN
                    be_d    = bus.be_i;
`endif
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                // Store commits on the edge closing the RESP cycle
                if (we_q && !err_q) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response status and load read are registered on the edge into RESP
        if (enter_resp) begin
            err_d  = acc_err;
            zero_d = acc_we | acc_err;
            if (!acc_we && !acc_err) begin
                ram_en = 1'b1;
            end
        end
    end

    // State and captured-request registers; reset aborts any access in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef DMEM_BYTE_EN_EN
            be_q    <= '0;
`endif
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef DMEM_BYTE_EN_EN
            be_q    <= be_d;
`endif
            err_q   <= err_d;
            zero_q  <= zero_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
`ifdef DMEM_BYTE_EN_EN
        .be_i    (be_q),
`endif
        .rdata_o (ram_rdata)
    );

    assign bus.ack_o   = (state_q == RESP);
    assign bus.busy_o  = (state_q != IDLE);
    assign bus.err_o   = err_q;
    assign bus.rdata_o = zero_q ? 32'h0 : ram_rdata;

endmodule
